// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width and the DAC FIFO priming state.
// Used by the CIC, the DAC sample FIFO and the pcm1702 interface wrappers.
package audio_pkg;
    localparam int SAMPLE_W = 20;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fifo_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/dac_sample_fifo_if.sv
// Sample handshake between the CIC producer, the FIFO and the serializer.
// master = producer/consumer side, slave = the FIFO itself.
interface dac_sample_fifo_if
    import audio_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 8
);
    localparam int CW = cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic              clr_flags;
    logic [DATA_W-1:0] rd_data;
    logic              sample_rdy;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_req, clr_flags,
        input  rd_data, sample_rdy, count, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_req, clr_flags,
        output rd_data, sample_rdy, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/sample_ram.sv
// DEPTH x DATA_W register array: synchronous write, combinational read.
// Contents are deliberately not reset; occupancy tracking makes them don't-care.
module sample_ram
    import audio_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/dac_sample_fifo.sv
// Elastic buffer between CIC output strobes and the PCM1702 serializer requests.
// Holds off serving until PRIME samples are buffered; flags overflow/underflow.
module dac_sample_fifo #(
    parameter int DATA_W = audio_pkg::SAMPLE_W,
    parameter int DEPTH  = 8,
    parameter int PRIME  = 4
) (
    input  logic                clk,
    input  logic                rst,
    dac_sample_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    audio_pkg::fifo_state_t state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              sample_rdy_q, sample_rdy_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              pop, wr_acc, wr_drop;
    logic [DATA_W-1:0] ram_rdata;

    sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // A full FIFO still accepts a write when a pop frees the slot the same cycle;
    // with wr_ptr == rd_ptr the read port sees the old entry before it is overwritten.
    always_comb begin
        pop     = bus.rd_req && (state_q == audio_pkg::RUN) && !empty_q;
        wr_acc  = bus.wr_en && (!full_q || pop);
        wr_drop = bus.wr_en && full_q && !pop;
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rd_data_d    = rd_data_q;
        sample_rdy_d = 1'b0;
        overflow_d   = (overflow_q && !bus.clr_flags) || wr_drop;
        underflow_d  = underflow_q && !bus.clr_flags;

        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

        if (wr_acc && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr_acc) count_d = count_q - CW'(1);

        unique case (state_q)
            audio_pkg::PRIME: begin
                // Serializer still gets a (silent) sample every frame while priming.
                if (bus.rd_req) begin
                    rd_data_d    = '0;
                    sample_rdy_d = 1'b1;
                end
                if (count_q >= CW'(PRIME)) state_d = audio_pkg::RUN;
            end
            audio_pkg::RUN: begin
                if (bus.rd_req) begin
                    sample_rdy_d = 1'b1;
                    if (!empty_q) begin
                        rd_data_d = ram_rdata;
                    end else begin
                        underflow_d = 1'b1;
                        state_d     = audio_pkg::PRIME;
                    end
                end
            end
            default: state_d = audio_pkg::PRIME;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= audio_pkg::PRIME;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            rd_data_q    <= '0;
            sample_rdy_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            rd_data_q    <= rd_data_d;
            sample_rdy_q <= sample_rdy_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.sample_rdy = sample_rdy_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule
